// File: rtl/acq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : acq_pkg
//  Description : Shared constants for the acquisition sequencer: state
//                encodings, capture modes and default widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package acq_pkg;

    // Default widths
    localparam int DEF_DATA_SIZE = 12;
    localparam int DEF_CNT_W     = 8;
    localparam int DEF_TMO_W     = 16;

    // Sequencer state encodings (visible on state_o)
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARMED   = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    // Capture modes; encoding 3 is reserved and behaves as Normal
    localparam logic [1:0] MODE_NORMAL = 2'd0;
    localparam logic [1:0] MODE_SINGLE = 2'd1;
    localparam logic [1:0] MODE_AUTO   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/acq_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : acq_sequencer_if
//  Description : Sample-stream and FIFO write-port bundle of the sequencer.
//                  sample_data_i  : ADC sample
//                  sample_valid_i : sample_data_i valid this cycle
//                  fifo_empty_i   : FIFO empty (read clock domain)
//                  fifo_full_i    : FIFO full
//                  w_en_o         : FIFO write enable (registered)
//                slave  : seen from the sequencer
//                master : seen from the ADC / FIFO side
//  Revision    : 1.0 - initial release
// ============================================================================
interface acq_sequencer_if #(
    parameter int DATA_SIZE = 12
);
    logic [DATA_SIZE-1:0] sample_data_i;
    logic                 sample_valid_i;
    logic                 fifo_empty_i;
    logic                 fifo_full_i;
    logic                 w_en_o;

    modport slave (
        input  sample_data_i,
        input  sample_valid_i,
        input  fifo_empty_i,
        input  fifo_full_i,
        output w_en_o
    );

    modport master (
        output sample_data_i,
        output sample_valid_i,
        output fifo_empty_i,
        output fifo_full_i,
        input  w_en_o
    );
endinterface
`default_nettype wire

// File: rtl/acq_sequencer_trig_detect.sv
`default_nettype none
// ============================================================================
//  Module      : trig_detect
//  Description : Threshold compare with previous/current flags. edge_o is a
//                one-cycle flag in the cycle after the valid sample that
//                crossed the threshold was registered.
//  Ports       : clk_i, rst_i (async active-low), clear_i (sync flag clear),
//                valid_i, sample_i, level_i, rising_i, edge_o
//  Revision    : 1.0 - initial release
// ============================================================================
module trig_detect #(
    parameter int DATA_SIZE = 12
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 valid_i,
    input  logic [DATA_SIZE-1:0] sample_i,
    input  logic [DATA_SIZE-1:0] level_i,
    input  logic                 rising_i,
    output logic                 edge_o
);
    logic r_thr_cur;
    logic r_thr_prev;
    logic r_have_cur;   // at least one sample since the last clear
    logic r_have_prev;  // at least two samples: r_thr_prev is meaningful
    logic r_fresh;      // a valid sample was registered on the last edge
    logic w_thr;

    assign w_thr = rising_i ? (sample_i >= level_i) : (sample_i < level_i);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_thr_cur   <= 1'b0;
            r_thr_prev  <= 1'b0;
            r_have_cur  <= 1'b0;
            r_have_prev <= 1'b0;
            r_fresh     <= 1'b0;
        end else if (clear_i) begin
            r_thr_cur   <= 1'b0;
            r_thr_prev  <= 1'b0;
            r_have_cur  <= 1'b0;
            r_have_prev <= 1'b0;
            r_fresh     <= 1'b0;
        end else if (valid_i) begin
            r_thr_cur   <= w_thr;
            r_thr_prev  <= r_thr_cur;
            r_have_cur  <= 1'b1;
            r_have_prev <= r_have_cur;
            r_fresh     <= 1'b1;
        end else begin
            r_fresh     <= 1'b0;
        end
    end

    // The first sample after a clear only primes the history; it cannot edge.
    assign edge_o = r_fresh & r_have_prev & r_thr_cur & ~r_thr_prev;

endmodule
`default_nettype wire

// File: rtl/acq_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : acq_sequencer
//  Description : Sequences one capture record at a time between the ADC
//                sample stream and the sample FIFO: arm, wait for a drained
//                FIFO, trigger (level/edge or Auto timeout), write a fixed
//                post-trigger count, signal done.
//  Ports       : clk_i, rst_i (async active-low)
//                bus            : sample stream + FIFO port (slave modport)
//                trig_level_i, trig_rising_i, mode_i, post_count_i,
//                timeout_i      : configuration, latched on (re-)arm
//                arm_i, abort_i : single-cycle control pulses
//                trigger_o, forced_o, busy_o, done_o, state_o : status
//  Revision    : 1.0 - initial release
// ============================================================================
module acq_sequencer
    import acq_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int TMO_W     = DEF_TMO_W
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    acq_sequencer_if.slave       bus,
    input  logic [DATA_SIZE-1:0] trig_level_i,
    input  logic                 trig_rising_i,
    input  logic [1:0]           mode_i,
    input  logic [CNT_W-1:0]     post_count_i,
    input  logic [TMO_W-1:0]     timeout_i,
    input  logic                 arm_i,
    input  logic                 abort_i,
    output logic                 trigger_o,
    output logic                 forced_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [1:0]           state_o
);
    logic [1:0]           r_state;
    logic [DATA_SIZE-1:0] r_level;
    logic                 r_rising;
    logic [1:0]           r_mode;
    logic [CNT_W-1:0]     r_post;
    logic [TMO_W-1:0]     r_tmo;
    logic [CNT_W:0]       r_cnt;     // one extra bit so a record of 2^CNT_W fits
    logic                 r_empty_meta, r_empty_s;
    logic                 r_full_meta,  r_full_s;
    logic                 r_w_en, r_trigger, r_forced, r_done;

    logic                 w_load_cfg;
    logic                 w_edge;
    logic                 w_is_auto;
    logic                 w_tmo_hit;
    logic [CNT_W:0]       w_rec_len;

    // Both FIFO flags cross from other domains; only synchronized copies used.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_empty_meta <= 1'b0;
            r_empty_s    <= 1'b0;
            r_full_meta  <= 1'b0;
            r_full_s     <= 1'b0;
        end else begin
            r_empty_meta <= bus.fifo_empty_i;
            r_empty_s    <= r_empty_meta;
            r_full_meta  <= bus.fifo_full_i;
            r_full_s     <= r_full_meta;
        end
    end

    // Initial arm from IDLE, or automatic re-arm out of DONE (not Single).
    assign w_load_cfg = !abort_i &&
                        ((r_state == IDLE && arm_i) ||
                         (r_state == DONE && r_mode != MODE_SINGLE));

    assign w_is_auto = (r_mode == MODE_AUTO);
    // Fires on the sample that takes the countdown to zero, or once it is zero.
    assign w_tmo_hit = (r_tmo == '0) ||
                       (r_tmo == TMO_W'(1) && bus.sample_valid_i);
    // A post count of zero encodes the maximum record length 2^CNT_W.
    assign w_rec_len = (r_post == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, r_post};

    trig_detect #(
        .DATA_SIZE (DATA_SIZE)
    ) u_trig_detect (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (w_load_cfg),
        .valid_i  (bus.sample_valid_i),
        .sample_i (bus.sample_data_i),
        .level_i  (r_level),
        .rising_i (r_rising),
        .edge_o   (w_edge)
    );

    // Configuration latch and Auto-mode timeout countdown
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_level  <= '0;
            r_rising <= 1'b0;
            r_mode   <= MODE_NORMAL;
            r_post   <= '0;
            r_tmo    <= '0;
        end else if (w_load_cfg) begin
            r_level  <= trig_level_i;
            r_rising <= trig_rising_i;
            r_mode   <= mode_i;
            r_post   <= post_count_i;
            r_tmo    <= timeout_i;
        end else if (r_state == ARMED && w_is_auto &&
                     bus.sample_valid_i && r_tmo != '0) begin
            r_tmo    <= r_tmo - TMO_W'(1);
        end
    end

    // Sequencer FSM; status pulses default low every cycle
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_w_en    <= 1'b0;
            r_trigger <= 1'b0;
            r_forced  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_w_en    <= 1'b0;
            r_trigger <= 1'b0;
            r_forced  <= 1'b0;
            r_done    <= 1'b0;
            if (abort_i) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (arm_i) begin
                            r_state <= ARMED;
                        end
                    end
                    ARMED: begin
                        // A real edge wins over a simultaneous timeout.
                        if (r_empty_s && (w_edge || (w_is_auto && w_tmo_hit))) begin
                            r_trigger <= 1'b1;
                            r_forced  <= !w_edge;
                            r_cnt     <= w_rec_len;
                            r_state   <= CAPTURE;
                        end
                    end
                    CAPTURE: begin
                        // The last write enable shows in the final CAPTURE
                        // cycle, so DONE itself never carries a write.
                        if (r_full_s || r_cnt == '0) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else if (bus.sample_valid_i) begin
                            r_w_en  <= 1'b1;
                            r_cnt   <= r_cnt - (CNT_W + 1)'(1);
                        end
                    end
                    DONE: begin
                        r_state <= (r_mode == MODE_SINGLE) ? IDLE : ARMED;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.w_en_o = r_w_en;
    assign trigger_o  = r_trigger;
    assign forced_o   = r_forced;
    assign done_o     = r_done;
    assign busy_o     = (r_state != IDLE);
    assign state_o    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_acq_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_acq_sequencer
//  Description : Self-checking bench for acq_sequencer: a directed vector
//                table for a Single-mode record, then hand-written sequences
//                for Normal, Auto, FIFO-full truncation, abort and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_acq_sequencer;
    localparam int DATA_SIZE = 12;
    localparam int CNT_W     = 8;
    localparam int TMO_W     = 16;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic [DATA_SIZE-1:0] trig_level_i;
    logic                 trig_rising_i;
    logic [1:0]           mode_i;
    logic [CNT_W-1:0]     post_count_i;
    logic [TMO_W-1:0]     timeout_i;
    logic                 arm_i, abort_i;
    logic                 trigger_o, forced_o, busy_o, done_o;
    logic [1:0]           state_o;

    int n_checks = 0;
    int n_fail   = 0;

    acq_sequencer_if #(.DATA_SIZE(DATA_SIZE)) bus ();

    acq_sequencer #(
        .DATA_SIZE (DATA_SIZE),
        .CNT_W     (CNT_W),
        .TMO_W     (TMO_W)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .bus           (bus),
        .trig_level_i  (trig_level_i),
        .trig_rising_i (trig_rising_i),
        .mode_i        (mode_i),
        .post_count_i  (post_count_i),
        .timeout_i     (timeout_i),
        .arm_i         (arm_i),
        .abort_i       (abort_i),
        .trigger_o     (trigger_o),
        .forced_o      (forced_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .state_o       (state_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        arm;
        logic        valid;
        logic [11:0] data;
        logic [1:0]  st;
        logic        trig;
        logic        frc;
        logic        wen;
        logic        dn;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [6:0] outs();
        return {state_o, trigger_o, forced_o, bus.w_en_o, done_o, busy_o};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int recs, wr, run, drain, nv, fs, drop;
        logic got, dn, emp;

        rst_i = 1'b0;
        trig_level_i = '0; trig_rising_i = 1'b0; mode_i = 2'd0;
        post_count_i = '0; timeout_i = '0; arm_i = 1'b0; abort_i = 1'b0;
        bus.sample_data_i = '0; bus.sample_valid_i = 1'b0;
        bus.fifo_empty_i = 1'b1; bus.fifo_full_i = 1'b0;
        #12;
        check("reset_outputs", 32'(outs()), 32'h0);
        @(negedge clk_i);
        rst_i = 1'b1;

        // ---------------- Single mode, rising, level 0x800, N=4 ----------
        trig_level_i = 12'h800; trig_rising_i = 1'b1; mode_i = 2'd1;
        post_count_i = 8'd4; timeout_i = 16'd0;
        repeat (3) tick();
        //           arm   valid data     st     trig  frc   wen   done
        vecs[0]  = '{1'b1, 1'b0, 12'h000, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 12'h700, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 12'h740, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 12'h780, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 12'h7C0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 12'h800, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 12'h840, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 12'h880, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 12'h8C0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 12'h900, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 12'h900, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 12'h900, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 12'h900, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 12'h900, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 14; i++) begin
            arm_i = vecs[i].arm;
            bus.sample_valid_i = vecs[i].valid;
            bus.sample_data_i  = vecs[i].data;
            tick();
            check($sformatf("single_vec%0d", i), 32'(outs()),
                  32'({vecs[i].st, vecs[i].trig, vecs[i].frc, vecs[i].wen,
                       vecs[i].dn, (vecs[i].st != 2'd0)}));
        end
        arm_i = 1'b0;

        // ---------------- Normal mode, falling, level 0x400, N=3 ---------
        mode_i = 2'd0; trig_rising_i = 1'b0; trig_level_i = 12'h400;
        post_count_i = 8'd3;
        arm_i = 1'b1; tick(); arm_i = 1'b0;
        recs = 0; wr = 0; run = 5; drain = 0;
        for (int c = 0; c < 400 && recs < 3; c++) begin
            bus.sample_valid_i = 1'b1;
            bus.sample_data_i  = ((c / 4) % 2 == 1) ? 12'hFFF : 12'h000;
            emp = bus.fifo_empty_i;
            tick();
            run = emp ? run + 1 : 0;
            if (trigger_o) check("normal_trig_needs_empty", 32'(run >= 3), 32'h1);
            if (forced_o)  check("normal_never_forced", 32'(forced_o), 32'h0);
            if (bus.w_en_o) begin
                wr++;
                bus.fifo_empty_i = 1'b0;
            end
            if (done_o) begin
                recs++;
                check("normal_record_len", 32'(wr), 32'd3);
                wr = 0;
                drain = 5;
            end else if (drain > 0) begin
                drain--;
                if (drain == 0) bus.fifo_empty_i = 1'b1;
            end
        end
        check("normal_records", 32'(recs), 32'd3);
        abort_i = 1'b1; tick(); abort_i = 1'b0;
        bus.fifo_empty_i = 1'b1; bus.sample_valid_i = 1'b0;
        repeat (4) tick();

        // ---------------- Auto mode, timeout 10, no real edge ------------
        mode_i = 2'd2; trig_rising_i = 1'b1; trig_level_i = 12'h800;
        post_count_i = 8'd3; timeout_i = 16'd10;
        bus.sample_data_i = 12'h100;
        arm_i = 1'b1; tick(); arm_i = 1'b0;
        nv = 0; got = 1'b0;
        for (int c = 0; c < 30 && !got; c++) begin
            bus.sample_valid_i = 1'b1;
            tick();
            nv++;
            if (trigger_o) begin
                got = 1'b1;
                check("auto_forced", 32'(forced_o), 32'h1);
                check("auto_trigger_sample", 32'(nv), 32'd10);
            end
        end
        check("auto_trigger_seen", 32'(got), 32'h1);
        wr = 0; dn = 1'b0;
        for (int c = 0; c < 10 && !dn; c++) begin
            tick();
            if (bus.w_en_o) wr++;
            if (done_o) dn = 1'b1;
        end
        check("auto_writes", 32'(wr), 32'd3);
        check("auto_done", 32'(dn), 32'h1);
        tick();
        check("auto_rearmed", 32'(state_o), 32'd1);
        abort_i = 1'b1; tick(); abort_i = 1'b0;
        bus.sample_valid_i = 1'b0;

        // ---------------- Auto timeout 0, N=8, FIFO full truncation ------
        timeout_i = 16'd0; post_count_i = 8'd8;
        arm_i = 1'b1; tick(); arm_i = 1'b0;
        check("tmo0_armed", 32'(state_o), 32'd1);
        tick();
        check("tmo0_forced_trigger", 32'({trigger_o, forced_o, state_o}), 32'b1110);
        wr = 0; fs = -1; drop = -1; dn = 1'b0;
        for (int c = 0; c < 30 && !dn; c++) begin
            bus.sample_valid_i = 1'b1;
            tick();
            if (fs >= 0) fs++;
            if (bus.w_en_o) wr++;
            else if (fs >= 0 && drop < 0) drop = fs;
            if (done_o) dn = 1'b1;
            if (wr == 3 && fs < 0) begin
                bus.fifo_full_i = 1'b1;
                fs = 0;
            end
        end
        check("full_writes_at_most_5", 32'(wr >= 3 && wr <= 5), 32'h1);
        check("full_wen_drop_latency", 32'(drop >= 1 && drop <= 3), 32'h1);
        check("full_done", 32'(dn), 32'h1);
        bus.fifo_full_i = 1'b0;
        abort_i = 1'b1; tick(); abort_i = 1'b0;
        repeat (3) tick();

        // ---------------- abort together with arm in mid-CAPTURE ---------
        arm_i = 1'b1; bus.sample_valid_i = 1'b0; tick(); arm_i = 1'b0;
        bus.sample_valid_i = 1'b1;
        repeat (3) tick();
        check("abort_pre_capture", 32'(state_o), 32'd2);
        abort_i = 1'b1; arm_i = 1'b1; tick(); abort_i = 1'b0; arm_i = 1'b0;
        check("abort_outputs", 32'(outs()), 32'h0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("abort_stays_idle", 32'({state_o, done_o, busy_o}), 32'h0);
        end

        // ---------------- asynchronous reset during CAPTURE --------------
        arm_i = 1'b1; bus.sample_valid_i = 1'b0; tick(); arm_i = 1'b0;
        bus.sample_valid_i = 1'b1;
        repeat (2) tick();
        check("reset_pre_capture", 32'({state_o, bus.w_en_o}), 32'b101);
        #3 rst_i = 1'b0;
        #1;
        check("reset_async_outputs", 32'(outs()), 32'h0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("reset_idle_until_arm", 32'(outs()), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
